// File: rtl/osc_mon_pkg.sv
// Shared types and width helpers for the oscillation monitor.
//   state_t  : monitor control state (IDLE, ARM, RUN)
//   tcnt_w   : toggle-counter width able to hold 0..window
//   streak_w : streak-counter width able to hold 0..confirm
package osc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic int tcnt_w(input int window);
        return $clog2(window + 1);
    endfunction

    function automatic int streak_w(input int confirm);
        return $clog2(confirm + 1);
    endfunction

endpackage

// File: rtl/osc_mon_chan.sv
// One monitored probe channel: edge detect, per-window toggle count,
// consecutive-hit streak, sticky detect flag and sticky mismatch flag.
//   clk, rst_n : clock, synchronous active-low reset
//   cap        : ARM cycle, load the sample register
//   run        : counting enabled (RUN with a valid previous sample)
//   win_end    : last cycle of the current window
//   clr        : clear sticky flag/mismatch (a coinciding set wins)
//   probe      : synchronised probe bit
//   exp_flag   : predicted oscillation, sampled at window end
//   flag       : sticky detected oscillation
//   mismatch   : sticky disagreement between flag and exp_flag
module osc_mon_chan
    import osc_mon_pkg::*;
#(
    parameter int WINDOW  = 16,
    parameter int THRESH  = 8,
    parameter int CONFIRM = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cap,
    input  logic run,
    input  logic win_end,
    input  logic clr,
    input  logic probe,
    input  logic exp_flag,
    output logic flag,
    output logic mismatch
);

    localparam int TCNT_W   = tcnt_w(WINDOW);
    localparam int STREAK_W = streak_w(CONFIRM);
    localparam logic [TCNT_W:0]     THR_C = (TCNT_W+1)'(THRESH);
    localparam logic [TCNT_W:0]     WIN_C = (TCNT_W+1)'(WINDOW);
    localparam logic [STREAK_W-1:0] CNF_C = STREAK_W'(CONFIRM);

    logic                prev;
    logic [TCNT_W-1:0]   tcnt;
    logic [STREAK_W-1:0] streak;

    logic                tgl;
    logic [TCNT_W:0]     tsum;
    logic                hit;
    logic [STREAK_W-1:0] streak_nxt;
    logic                set;
    logic                flag_nxt;
    logic                mis_nxt;

    always_comb begin
        tgl        = run & (probe ^ prev);
        // The toggle seen in the window-end cycle still counts toward that window.
        tsum       = {1'b0, tcnt} + {{TCNT_W{1'b0}}, tgl};
        hit        = (tsum >= THR_C);
        streak_nxt = '0;
        if (hit)
            streak_nxt = (streak == CNF_C) ? streak : streak + 1'b1;
        set        = win_end & hit & (streak_nxt == CNF_C);
        // Set has priority over clr so no detection event is lost.
        flag_nxt   = set | (flag & ~clr);
        mis_nxt    = (win_end & (flag_nxt != exp_flag)) | (mismatch & ~clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev     <= 1'b0;
            tcnt     <= '0;
            streak   <= '0;
            flag     <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            prev <= (cap | run) ? probe : 1'b0;
            if (!run) begin
                tcnt   <= '0;
                streak <= '0;
            end else if (win_end) begin
                tcnt   <= '0;
                streak <= streak_nxt;
            end else begin
                tcnt <= (tsum > WIN_C) ? WIN_C[TCNT_W-1:0] : tsum[TCNT_W-1:0];
            end
            flag     <= flag_nxt;
            mismatch <= mis_nxt;
        end
    end

endmodule

// File: rtl/osc_monitor.sv
// Multi-channel oscillation detector for combinational-loop probe nets.
// Counts probe toggles per channel over fixed windows and raises a sticky
// flag after CONFIRM consecutive windows at or above THRESH toggles; the
// flags are compared with a predicted vector at every window end.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : monitoring enable; 0 holds window/toggle/streak state at zero
//   clr        : pulse clearing osc_flag and mismatch
//   probe      : NUM_CH synchronised probe bits
//   exp_flag   : NUM_CH predicted oscillation flags
//   osc_flag   : NUM_CH sticky detection flags
//   osc_any    : OR of osc_flag
//   win_done   : pulse on the last cycle of each window
//   mismatch   : NUM_CH sticky flag/prediction disagreement
module osc_monitor
    import osc_mon_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int WINDOW  = 16,
    parameter int THRESH  = 8,
    parameter int CONFIRM = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] probe,
    input  logic [NUM_CH-1:0] exp_flag,
    output logic [NUM_CH-1:0] osc_flag,
    output logic              osc_any,
    output logic              win_done,
    output logic [NUM_CH-1:0] mismatch
);

    localparam int WCNT_W = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW - 1);

    state_t             state, state_nxt;
    logic [WCNT_W-1:0]  wcnt;
    logic               prev_valid;
    logic               cap;
    logic               run;
    logic               win_end;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = ARM;
            ARM:     state_nxt = en ? RUN : IDLE;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        cap     = (state == ARM) & en;
        run     = (state == RUN) & en & prev_valid;
        win_end = run & (wcnt == WLAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wcnt       <= '0;
            prev_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            // The sample register holds a real probe value exactly while in RUN.
            prev_valid <= (state_nxt == RUN);
            if (!run || win_end)
                wcnt <= '0;
            else
                wcnt <= wcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        osc_mon_chan #(
            .WINDOW  (WINDOW),
            .THRESH  (THRESH),
            .CONFIRM (CONFIRM)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .cap      (cap),
            .run      (run),
            .win_end  (win_end),
            .clr      (clr),
            .probe    (probe[i]),
            .exp_flag (exp_flag[i]),
            .flag     (osc_flag[i]),
            .mismatch (mismatch[i])
        );
    end

    assign win_done = win_end;
    assign osc_any  = |osc_flag;

endmodule
